// File: rtl/hazard_pkg.sv
// ============================================================================
// hazard_pkg : shared encodings for the pipeline hazard controller
// Rev 1.0
// ============================================================================
`default_nettype none

package hazard_pkg;

   localparam int DEF_AW = 5;

   localparam logic [1:0] ST_RUN       = 2'd0;
   localparam logic [1:0] ST_STEP_HOLD = 2'd1;
   localparam logic [1:0] ST_HALT      = 2'd2;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

`default_nettype wire

// File: rtl/hazard_src_match.sv
// ============================================================================
// hazard_src_match : compares one source operand against E/M/W destinations
// Rev 1.0
// ============================================================================
`default_nettype none

module hazard_src_match
   import hazard_pkg::*;
#(
   parameter int AW = DEF_AW
) (
   input  logic [AW-1:0] i_src_d,
   input  logic          i_used_d,
   input  logic [AW-1:0] i_src_e,
   input  logic [AW-1:0] i_dst_e,
   input  logic [AW-1:0] i_dst_m,
   input  logic [AW-1:0] i_dst_w,
   output logic          o_match_e,
   output logic          o_match_m,
   output logic          o_ex_match_m,
   output logic          o_ex_match_w
);

   // $0 is hardwired, so it can never carry a real dependency
   logic w_live_d;
   logic w_live_e;

   assign w_live_d = i_used_d & (|i_src_d);
   assign w_live_e = |i_src_e;

   assign o_match_e    = w_live_d & (i_src_d == i_dst_e);
   assign o_match_m    = w_live_d & (i_src_d == i_dst_m);
   assign o_ex_match_m = w_live_e & (i_src_e == i_dst_m);
   assign o_ex_match_w = w_live_e & (i_src_e == i_dst_w);

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// hazard_ctrl : stall/flush/forward control with debug halt/step FSM
// Rev 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int AW          = DEF_AW,
   parameter int NUM_SRC     = 2,
   parameter int TO_W        = 8,
   parameter int MEM_TIMEOUT = 200
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_SRC*AW-1:0] src_addr_d,
   input  logic [NUM_SRC-1:0]   src_used_d,
   input  logic                 branch_d,
   input  logic                 jump_d,
   input  logic                 jr_d,
   input  logic                 pcsrc_d,
   input  logic [NUM_SRC*AW-1:0] src_addr_e,
   input  logic [AW-1:0]        dst_addr_e,
   input  logic [AW-1:0]        dst_addr_m,
   input  logic [AW-1:0]        dst_addr_w,
   input  logic                 regwrite_e,
   input  logic                 regwrite_m,
   input  logic                 regwrite_w,
   input  logic                 memtoreg_e,
   input  logic                 memtoreg_m,
   input  logic                 mem_busy,
   input  logic                 trap,
   input  logic                 step_mode,
   input  logic                 step_req,
   output logic                 stall_f,
   output logic                 stall_d,
   output logic                 stall_e,
   output logic                 stall_m,
   output logic                 flush_d,
   output logic                 flush_e,
   output logic [2*NUM_SRC-1:0] fwd_e,
   output logic [NUM_SRC-1:0]   fwd_d,
   output logic                 halted,
   output logic                 mem_timeout
);

   localparam logic [TO_W-1:0] c_TO_LAST = TO_W'(MEM_TIMEOUT - 1);

   logic [1:0]      r_state;
   logic            r_step_q;
   logic [TO_W-1:0] r_busy_cnt;
   logic            r_mem_timeout;

   logic [1:0]         w_state_nxt;
   logic               w_to_set;
   logic               w_timeout_hit;
   logic               w_step_pulse;
   logic               w_br_dep;
   logic               w_id_hazard;
   logic [NUM_SRC-1:0] w_match_e;
   logic [NUM_SRC-1:0] w_match_m;
   logic [NUM_SRC-1:0] w_ex_match_m;
   logic [NUM_SRC-1:0] w_ex_match_w;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
         hazard_src_match #(.AW(AW)) u_match (
            .i_src_d      (src_addr_d[gi*AW +: AW]),
            .i_used_d     (src_used_d[gi]),
            .i_src_e      (src_addr_e[gi*AW +: AW]),
            .i_dst_e      (dst_addr_e),
            .i_dst_m      (dst_addr_m),
            .i_dst_w      (dst_addr_w),
            .o_match_e    (w_match_e[gi]),
            .o_match_m    (w_match_m[gi]),
            .o_ex_match_m (w_ex_match_m[gi]),
            .o_ex_match_w (w_ex_match_w[gi])
         );

         assign fwd_e[2*gi +: 2] = rst                                 ? FWD_REG :
                                   (regwrite_m & w_ex_match_m[gi])     ? FWD_MEM :
                                   (regwrite_w & w_ex_match_w[gi])     ? FWD_WB  :
                                                                         FWD_REG;
         assign fwd_d[gi] = ~rst & regwrite_m & ~memtoreg_m & w_match_m[gi];
      end
   endgenerate

   assign w_step_pulse  = step_req & ~r_step_q;
   assign w_timeout_hit = mem_busy & (r_busy_cnt == c_TO_LAST);
   assign w_br_dep      = branch_d | jr_d;

   // Load-use, branch-on-EX-result and branch-on-MEM-load all need one bubble
   assign w_id_hazard = (regwrite_e & memtoreg_e & (|w_match_e))
                      | (w_br_dep & regwrite_e & (|w_match_e))
                      | (w_br_dep & regwrite_m & memtoreg_m & (|w_match_m));

   always_comb begin
      w_state_nxt = r_state;
      w_to_set    = 1'b0;
      if (trap) begin
         w_state_nxt = ST_HALT;
      end else if ((r_state != ST_HALT) && w_timeout_hit) begin
         w_state_nxt = ST_HALT;
         w_to_set    = 1'b1;
      end else begin
         case (r_state)
            ST_RUN:       if (step_mode)  w_state_nxt = ST_STEP_HOLD;
            ST_STEP_HOLD: if (!step_mode) w_state_nxt = ST_RUN;
            default:      w_state_nxt = r_state;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_RUN;
         r_step_q      <= 1'b0;
         r_busy_cnt    <= '0;
         r_mem_timeout <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_step_q <= step_req;
         if (!mem_busy) begin
            r_busy_cnt <= '0;
         end else if (r_busy_cnt != '1) begin
            r_busy_cnt <= r_busy_cnt + 1'b1;
         end
         if (w_to_set) begin
            r_mem_timeout <= 1'b1;
         end
      end
   end

   always_comb begin
      stall_f = 1'b0;
      stall_d = 1'b0;
      stall_e = 1'b0;
      stall_m = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
      if (!rst) begin
         if ((r_state == ST_HALT) || mem_busy) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
         end else if (((r_state == ST_STEP_HOLD) && !w_step_pulse) || w_id_hazard) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
         end else begin
            flush_d = pcsrc_d | jump_d;
         end
      end
   end

   assign halted      = ~rst & (r_state == ST_HALT);
   assign mem_timeout = ~rst & r_mem_timeout;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// tb_hazard_ctrl : directed self-checking bench for hazard_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

   localparam int AW = 5;
   localparam int NS = 2;
   localparam int MT = 200;

   logic           clk = 1'b0;
   logic           rst;
   logic [NS*AW-1:0] src_addr_d, src_addr_e;
   logic [NS-1:0]  src_used_d;
   logic           branch_d, jump_d, jr_d, pcsrc_d;
   logic [AW-1:0]  dst_addr_e, dst_addr_m, dst_addr_w;
   logic           regwrite_e, regwrite_m, regwrite_w, memtoreg_e, memtoreg_m;
   logic           mem_busy, trap, step_mode, step_req;
   logic           stall_f, stall_d, stall_e, stall_m, flush_d, flush_e;
   logic [2*NS-1:0] fwd_e;
   logic [NS-1:0]  fwd_d;
   logic           halted, mem_timeout;
   logic [5:0]     ctl;

   int checks = 0;
   int errors = 0;
   int n_free;

   assign ctl = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e};

   always #5 clk = ~clk;

   hazard_ctrl #(.AW(AW), .NUM_SRC(NS), .TO_W(8), .MEM_TIMEOUT(MT)) dut (
      .clk(clk), .rst(rst),
      .src_addr_d(src_addr_d), .src_used_d(src_used_d),
      .branch_d(branch_d), .jump_d(jump_d), .jr_d(jr_d), .pcsrc_d(pcsrc_d),
      .src_addr_e(src_addr_e),
      .dst_addr_e(dst_addr_e), .dst_addr_m(dst_addr_m), .dst_addr_w(dst_addr_w),
      .regwrite_e(regwrite_e), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
      .memtoreg_e(memtoreg_e), .memtoreg_m(memtoreg_m),
      .mem_busy(mem_busy), .trap(trap), .step_mode(step_mode), .step_req(step_req),
      .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
      .flush_d(flush_d), .flush_e(flush_e),
      .fwd_e(fwd_e), .fwd_d(fwd_d), .halted(halted), .mem_timeout(mem_timeout)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      src_addr_d = '0; src_addr_e = '0; src_used_d = '0;
      branch_d = 0; jump_d = 0; jr_d = 0; pcsrc_d = 0;
      dst_addr_e = '0; dst_addr_m = '0; dst_addr_w = '0;
      regwrite_e = 0; regwrite_m = 0; regwrite_w = 0;
      memtoreg_e = 0; memtoreg_m = 0;
      mem_busy = 0; trap = 0; step_mode = 0; step_req = 0;
   endtask

   initial begin
      clr();
      rst = 1'b1;
      // Reset forces outputs low even with hazards and forwards present
      regwrite_e = 1; memtoreg_e = 1; dst_addr_e = 5'd3;
      src_addr_d = 10'd3; src_used_d = 2'b01; jump_d = 1;
      regwrite_m = 1; dst_addr_m = 5'd3; src_addr_e = 10'd3;
      #1;
      chk("rst_ctl", 32'(ctl), 32'h0);
      chk("rst_fwd_e", 32'(fwd_e), 32'h0);
      chk("rst_fwd_d", 32'(fwd_d), 32'h0);
      chk("rst_halted", 32'(halted), 32'h0);
      tick();
      rst = 1'b0;
      clr();
      #1;
      chk("idle_ctl", 32'(ctl), 32'h0);

      // Load-use on rs
      regwrite_e = 1; memtoreg_e = 1; dst_addr_e = 5'd3;
      src_addr_d = 10'd3; src_used_d = 2'b01;
      #1;
      chk("lu_stall", 32'(ctl), 32'b110001);
      tick();
      clr();
      regwrite_m = 1; memtoreg_m = 1; dst_addr_m = 5'd3;
      src_addr_e = 10'd3; src_addr_d = 10'd3; src_used_d = 2'b01;
      #1;
      chk("lu_after_ctl", 32'(ctl), 32'h0);
      chk("lu_after_fwd", 32'(fwd_e), 32'b0010);
      tick();
      // Operand not used -> no hazard
      clr();
      regwrite_e = 1; memtoreg_e = 1; dst_addr_e = 5'd3;
      src_addr_d = 10'd3; src_used_d = 2'b00;
      #1;
      chk("lu_unused", 32'(ctl), 32'h0);
      // $0 on rt never matches
      src_addr_d = 10'd0; src_used_d = 2'b10; dst_addr_e = 5'd0;
      #1;
      chk("lu_zero", 32'(ctl), 32'h0);
      tick();

      // beq depending on an ALU result in EX
      clr();
      branch_d = 1; src_addr_d = 10'd5; src_used_d = 2'b11;
      regwrite_e = 1; dst_addr_e = 5'd5;
      #1;
      chk("br_ex_stall", 32'(ctl), 32'b110001);
      tick();
      regwrite_e = 0; dst_addr_e = 5'd0;
      regwrite_m = 1; dst_addr_m = 5'd5; pcsrc_d = 1;
      #1;
      chk("br_fwd_d", 32'(fwd_d), 32'b01);
      chk("br_flush_d", 32'(ctl), 32'b000010);
      // Same branch but MEM holds a load -> stall, no ID forward
      memtoreg_m = 1;
      #1;
      chk("br_mem_load", 32'(ctl), 32'b110001);
      chk("br_mem_fwd_d", 32'(fwd_d), 32'b00);
      tick();

      // EX forwarding priority on rt
      clr();
      src_addr_e = {5'd7, 5'd0};
      regwrite_m = 1; dst_addr_m = 5'd7;
      regwrite_w = 1; dst_addr_w = 5'd7;
      #1;
      chk("fwd_mem_wins", 32'(fwd_e), 32'b1000);
      regwrite_m = 0;
      #1;
      chk("fwd_wb", 32'(fwd_e), 32'b0100);
      regwrite_m = 1; src_addr_e = '0; dst_addr_m = '0; dst_addr_w = '0;
      #1;
      chk("fwd_zero", 32'(fwd_e), 32'b0000);
      chk("fwd_zero_ctl", 32'(ctl), 32'h0);
      tick();

      // Single step
      clr();
      step_mode = 1;
      #1;
      chk("step_enter_ctl", 32'(ctl), 32'h0);
      tick();
      chk("step_hold", 32'(ctl), 32'b110001);
      step_req = 1;
      n_free = 0;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (!stall_f) n_free++;
         tick();
      end
      chk("step_one_free", 32'(n_free), 32'd1);
      step_req = 0;
      #1;
      chk("step_release", 32'(stall_f), 32'd1);
      tick();
      step_req = 1;
      n_free = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         if (!stall_f) n_free++;
         tick();
      end
      chk("step_repress", 32'(n_free), 32'd1);
      step_req = 0; step_mode = 0;
      #1;
      chk("step_exit_hold", 32'(ctl), 32'b110001);
      tick();
      chk("step_run", 32'(ctl), 32'h0);

      // Short memory wait: full stall, jump flush suppressed
      clr();
      mem_busy = 1; jump_d = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("busy_stall", 32'(ctl), 32'b111100);
         tick();
      end
      mem_busy = 0;
      #1;
      chk("busy_end_flush", 32'(ctl), 32'b000010);
      tick();
      // Timeout: counter must have cleared, so 199 busy edges stay running
      jump_d = 0; mem_busy = 1;
      repeat (MT - 1) tick();
      chk("to_not_yet", 32'(halted), 32'd0);
      tick();
      chk("to_halted", 32'(halted), 32'd1);
      chk("to_flag", 32'(mem_timeout), 32'd1);
      tick();
      mem_busy = 0; jump_d = 1;
      #1;
      chk("to_halt_ctl", 32'(ctl), 32'b111100);
      repeat (3) tick();
      chk("to_persist_h", 32'(halted), 32'd1);
      chk("to_persist_t", 32'(mem_timeout), 32'd1);
      rst = 1;
      #1;
      chk("to_rst_ctl", 32'(ctl), 32'h0);
      chk("to_rst_h", 32'(halted), 32'd0);
      tick();
      rst = 0; jump_d = 0;
      #1;
      chk("to_clear_h", 32'(halted), 32'd0);
      chk("to_clear_t", 32'(mem_timeout), 32'd0);

      // Trap halts permanently until reset
      trap = 1;
      #1;
      chk("trap_pre", 32'(halted), 32'd0);
      tick();
      trap = 0;
      #1;
      chk("trap_halt", 32'(halted), 32'd1);
      chk("trap_no_to", 32'(mem_timeout), 32'd0);
      repeat (5) tick();
      chk("trap_persist", 32'(halted), 32'd1);
      rst = 1;
      tick();
      rst = 0; step_mode = 1;
      #1;
      chk("trap_rst_h", 32'(halted), 32'd0);
      chk("trap_rst_ctl", 32'(ctl), 32'h0);
      tick();
      chk("trap_rst_run", 32'(ctl), 32'b110001);
      step_mode = 0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
